msu_square_sequencer: RTL

- Initiator-side controller for the modular squaring unit (MSU) squarer.
- Accepts a job (starting value x, iteration count T) over a valid/ready handshake.
- Pulses the squarer's start with sq_in = x, counts completed squarings via the squarer's valid/valid_toggle, and captures sq_out after exactly T squarings.
- Returns the result over a second valid/ready handshake. It sits between the host/AXI job interface and the squarer, which free-runs once started.

---
 rtl/msu_square_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/msu_square_sequencer.sv
// rtl/msu_square_sequencer.sv - job sequencer that starts the MSU squarer and captures x^(2^T)
module msu_square_sequencer #(
    parameter int MOD_LEN = 1024,
    parameter int T_WIDTH = 64
) (
    input  logic [15:0]        clk_phase,
    input  logic               reset,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic [MOD_LEN-1:0] job_x,
    input  logic [T_WIDTH-1:0] job_t,
    input  logic               abort,
    output logic               sq_start,
    output logic [MOD_LEN-1:0] sq_in,
    input  logic [MOD_LEN-1:0] sq_out,
    input  logic               sq_valid,
    input  logic               sq_valid_toggle,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [MOD_LEN-1:0] res_y,
    output logic [T_WIDTH-1:0] progress,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [MOD_LEN-1:0] sq_in_q, sq_in_d;
    logic [MOD_LEN-1:0] res_y_q, res_y_d;
    logic [T_WIDTH-1:0] t_q, t_d;
    logic [T_WIDTH-1:0] progress_q, progress_d;
    logic               prev_tog_q, prev_tog_d;

    // Only phase 0 clocks this block; the other phases are routed past it.
    logic unused_phase;
    assign unused_phase = ^clk_phase[15:1];

    always_ff @(posedge clk_phase[0]) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sq_in_q    <= '0;
            res_y_q    <= '0;
            t_q        <= '0;
            progress_q <= '0;
            prev_tog_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sq_in_q    <= sq_in_d;
            res_y_q    <= res_y_d;
            t_q        <= t_d;
            progress_q <= progress_d;
            prev_tog_q <= prev_tog_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sq_in_d    = sq_in_q;
        res_y_d    = res_y_q;
        t_d        = t_q;
        progress_d = progress_q;
        prev_tog_d = prev_tog_q;

        case (state_q)
            S_IDLE: begin
                if (job_valid) begin
                    sq_in_d    = job_x;
                    t_d        = job_t;
                    progress_d = '0;
                    if (job_t == '0) begin
                        res_y_d = job_x;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                // Start does not move the toggle, so this is the baseline for RUN.
                prev_tog_d = sq_valid_toggle;
                state_d    = S_RUN;
            end
            S_RUN: begin
                if (sq_valid && (sq_valid_toggle != prev_tog_q)) begin
                    progress_d = progress_q + T_WIDTH'(1);
                    prev_tog_d = sq_valid_toggle;
                    if ((progress_q + T_WIDTH'(1)) == t_q) begin
                        res_y_d = sq_out;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over a same-edge capture and leaves the old result untouched.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            res_y_d = res_y_q;
        end
    end

    assign job_ready = (state_q == S_IDLE);
    assign sq_start  = (state_q == S_LOAD);
    assign res_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign sq_in     = sq_in_q;
    assign res_y     = res_y_q;
    assign progress  = progress_q;

endmodule
